// File: rtl/math_arbiter_if.sv
// -----------------------------------------------------------------------------
// math_arbiter_if
// Groups the two request channels and the response channel of math_arbiter.
//
// Signals:
//   req0_valid/op/a/b  : requester 0 operation (op 0 = A+B, 1 = A-B)
//   req0_ready         : requester 0 accepted this cycle
//   req1_*             : same as req0_* for requester 1
//   rsp_valid          : response available
//   rsp_ready          : consumer accepts the response
//   rsp_id             : requester that issued the operation
//   rsp_result         : 4-bit result, mod 16
//   rsp_carry          : carry-out for add, borrow (A < B unsigned) for sub
//   rsp_ovf            : two's-complement overflow
//
// Modports:
//   master : requesters + response consumer (drive requests, accept responses)
//   slave  : the arbiter (accepts requests, produces responses)
// -----------------------------------------------------------------------------
interface math_arbiter_if;
    logic       req0_valid;
    logic       req0_op;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req0_ready;

    logic       req1_valid;
    logic       req1_op;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       req1_ready;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_ovf;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf,
        input  rsp_ready
    );
endinterface

// File: rtl/math_arbiter.sv
// -----------------------------------------------------------------------------
// math_arbiter
// Round-robin controller sharing one 4-bit add/subtract datapath between two
// requesters. A granted request is latched in IDLE, executed for one cycle in
// EXEC, and its registered result is presented in RESP until the consumer
// takes it.
//
// Parameters:
//   RR_INIT  : requester holding priority after reset (0 or 1)
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : math_arbiter_if.slave (request and response channels)
//   busy     : high whenever the FSM is not in IDLE
//   ops_done : completed-response counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module math_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    math_arbiter_if.slave        bus,
    output logic                 busy,
    output logic [7:0]           ops_done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       prio_q, prio_d;

    // Operand registers, loaded on accept
    logic       op_q;
    logic       id_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    // Response registers, loaded at the end of EXEC
    logic       rsp_id_q;
    logic [3:0] rsp_result_q;
    logic       rsp_carry_q;
    logic       rsp_ovf_q;

    logic [7:0] ops_done_q;

    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       rsp_fire;

    // Shared datapath (math_block)
    logic [3:0] mb_b_eff;
    logic [4:0] mb_sum;
    logic [3:0] mb_result;
    logic       mb_carry;
    logic       mb_ovf;

    // -------------------------------------------------------------------------
    // FSM next state, grants and priority update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        grant0   = 1'b0;
        grant1   = 1'b0;
        rsp_fire = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A lone requester wins regardless of prio; on a tie prio decides
                grant0 = bus.req0_valid & (~prio_q | ~bus.req1_valid);
                grant1 = bus.req1_valid & ( prio_q | ~bus.req0_valid);
                if (grant0 | grant1) begin
                    state_d = StExec;
                    // Priority passes to the requester that was not granted
                    prio_d  = grant0;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                rsp_fire = bus.rsp_ready;
                if (rsp_fire) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign accept = grant0 | grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prio_q  <= RR_INIT;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 1'b0;
            id_q <= 1'b0;
            a_q  <= 4'd0;
            b_q  <= 4'd0;
        end else if (accept) begin
            // grant0 and grant1 are mutually exclusive
            op_q <= grant1 ? bus.req1_op : bus.req0_op;
            id_q <= grant1;
            a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
        end
    end

    // -------------------------------------------------------------------------
    // math_block: A + B, or A - B computed as A + ~B + 1
    // -------------------------------------------------------------------------
    always_comb begin
        mb_b_eff  = op_q ? ~b_q : b_q;
        mb_sum    = {1'b0, a_q} + {1'b0, mb_b_eff} + {4'd0, op_q};
        mb_result = mb_sum[3:0];
        // For subtract the adder carry-out means "no borrow"
        mb_carry  = op_q ? ~mb_sum[4] : mb_sum[4];
        // Overflow when both addend signs agree and the result sign differs;
        // using ~B for subtract folds the "signs differ" case into the same test
        mb_ovf    = (a_q[3] == mb_b_eff[3]) & (mb_result[3] != a_q[3]);
    end

    // -------------------------------------------------------------------------
    // Response registers: written only at the end of EXEC, so they stay stable
    // through RESP and keep their value after the handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else if (state_q == StExec) begin
            rsp_id_q     <= id_q;
            rsp_result_q <= mb_result;
            rsp_carry_q  <= mb_carry;
            rsp_ovf_q    <= mb_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_q <= 8'd0;
        end else if (rsp_fire) begin
            ops_done_q <= ops_done_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign busy           = (state_q != StIdle);
    assign ops_done       = ops_done_q;

endmodule

// File: tb/tb_math_arbiter.sv
module tb_math_arbiter;

    typedef struct {
        logic       id;
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       v;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] ops_done;

    math_arbiter_if bus ();

    math_arbiter #(.RR_INIT(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_ops = 0;
    vec_t sb_q[$];
    int   lat_q[$];
    logic prev_valid = 1'b0;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference model from plain integer arithmetic
    function automatic vec_t mk(input logic id, input logic op, input logic [3:0] a,
                                input logic [3:0] b);
        vec_t v;
        int ua, ub, sa, sbv, r;
        ua = int'(a);
        ub = int'(b);
        sa  = a[3] ? ua - 16 : ua;
        sbv = b[3] ? ub - 16 : ub;
        v.id = id; v.op = op; v.a = a; v.b = b;
        if (op) begin
            v.res = 4'((ua - ub) & 15);
            v.c   = (ua < ub);
            r     = sa - sbv;
        end else begin
            v.res = 4'((ua + ub) & 15);
            v.c   = (ua + ub > 15);
            r     = sa + sbv;
        end
        v.v = (r > 7) || (r < -8);
        return v;
    endfunction

    task automatic set_req(input logic id, input logic valid, input logic op,
                           input logic [3:0] a, input logic [3:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = valid; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = valid; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Wait (bounded) until requester id sees ready at a negedge
    task automatic wait_ready(input logic id);
        bit got = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout("wait_ready");
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 40; t++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            timeout("drain");
            sb_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        sb_q.push_back(v);
        wait_ready(v.id);
        @(posedge clk); #1;
        set_req(v.id, 1'b0, 1'b0, 4'd0, 4'd0);
        wait_drain();
    endtask

    // Scoreboard monitor: latency on rsp_valid rise, payload on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req0_valid && bus.req0_ready) lat_q.push_back(cyc + 2);
            if (bus.req1_valid && bus.req1_ready) lat_q.push_back(cyc + 2);
            if (bus.rsp_valid && !prev_valid) begin
                if (lat_q.size() == 0) timeout("latency_queue_empty");
                else check("latency", 32'(cyc), 32'(lat_q.pop_front()));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    timeout("unexpected_response");
                end else begin
                    vec_t e;
                    e = sb_q.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                    check("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
                    check("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.v));
                end
                exp_ops = (exp_ops + 1) & 255;
            end
            prev_valid = bus.rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin : main
        vec_t rr0[2];
        vec_t rr1[2];
        vec_t bp;
        int   g0, g1, nacc;
        int   acc_id[4];
        int   acc_cyc[4];

        //            id    op    a      b      res    c     v
        tbl[0] = '{1'b0, 1'b0, 4'h7, 4'h9, 4'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'h4, 4'h4, 4'h8, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 4'h3, 4'h5, 4'hE, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'h7, 4'hF, 4'h8, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 4'h3, 4'h2, 4'h5, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0};

        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ops_done", 32'(ops_done), 32'd0);
        check("reset_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin: both valid, four transactions
        rr0[0] = mk(1'b0, 1'b0, 4'd1, 4'd2);
        rr0[1] = mk(1'b0, 1'b1, 4'd2, 4'd7);
        rr1[0] = mk(1'b1, 1'b1, 4'd6, 4'd1);
        rr1[1] = mk(1'b1, 1'b0, 4'd7, 4'd7);
        sb_q.push_back(rr0[0]);
        sb_q.push_back(rr1[0]);
        sb_q.push_back(rr0[1]);
        sb_q.push_back(rr1[1]);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, rr0[0].op, rr0[0].a, rr0[0].b);
        set_req(1'b1, 1'b1, rr1[0].op, rr1[0].a, rr1[0].b);
        g0 = 0; g1 = 0; nacc = 0;
        for (int t = 0; t < 60 && nacc < 4; t++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) check("rr_one_ready", 32'd2, 32'd1);
            if (bus.req0_ready) begin
                acc_id[nacc] = 0; acc_cyc[nacc] = cyc; nacc++; g0++;
            end else if (bus.req1_ready) begin
                acc_id[nacc] = 1; acc_cyc[nacc] = cyc; nacc++; g1++;
            end
            @(posedge clk); #1;
            if (g0 < 2) set_req(1'b0, 1'b1, rr0[g0].op, rr0[g0].a, rr0[g0].b);
            else        set_req(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            if (g1 < 2) set_req(1'b1, 1'b1, rr1[g1].op, rr1[g1].a, rr1[g1].b);
            else        set_req(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        end
        if (nacc < 4) begin
            timeout("rr_accepts");
        end else begin
            for (int i = 0; i < 4; i++) check("rr_id_order", 32'(acc_id[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        end
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        wait_drain();
        check("rr_ops_done", 32'(ops_done), 32'd4);

        // Table-driven single-requester vectors
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);
        check("table_ops_done", 32'(ops_done), 32'(exp_ops));

        // Backpressure: hold RESP with req0 waiting
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bp = mk(1'b1, 1'b1, 4'd9, 4'd3);
        set_req(1'b1, 1'b1, bp.op, bp.a, bp.b);
        sb_q.push_back(bp);
        wait_ready(1'b1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        set_req(1'b0, 1'b1, 1'b0, 4'd2, 4'd3);
        sb_q.push_back(mk(1'b0, 1'b0, 4'd2, 4'd3));
        begin
            bit seen = 0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (bus.rsp_valid) begin seen = 1; break; end
            end
            if (!seen) timeout("bp_rsp_valid");
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'(bp.id));
            check("bp_rsp_result", 32'(bus.rsp_result), 32'(bp.res));
            check("bp_rsp_flags", 32'({bus.rsp_carry, bus.rsp_ovf}), 32'({bp.c, bp.v}));
            check("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            check("bp_ops_done", 32'(ops_done), 32'(exp_ops));
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_handshake", 32'(bus.req0_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_after_handshake", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        wait_drain();
        check("bp_ops_done_final", 32'(ops_done), 32'(exp_ops));

        // Reset while in RESP
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 4'd5, 4'd6);
        sb_q.push_back(mk(1'b0, 1'b0, 4'd5, 4'd6));
        wait_ready(1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        check("pre_reset_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("pre_reset_result", 32'(bus.rsp_result), 32'hB);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("async_ops_done", 32'(ops_done), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        sb_q.delete();
        lat_q.delete();
        exp_ops = 0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        // Priority back at RR_INIT: tie goes to requester 0 (checked mid-cycle)
        set_req(1'b0, 1'b1, 1'b0, 4'd1, 4'd1);
        set_req(1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
        #1;
        check("post_reset_prio", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        set_req(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        set_req(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
